// File: rtl/divn_pkg.sv
// Shared constants and helpers for the streaming divisibility checker.
package divn_pkg;

  // Error flag vector layout; only the illegal-modulus flag exists today.
  localparam int unsigned ERR_NUM         = 1;
  localparam int unsigned ERR_ILLEGAL_MOD = 0;

  function automatic int calc_mw(input int max_mod);
    return $clog2(max_mod + 1);
  endfunction

endpackage

// File: rtl/divn_step.sv
// One shift-and-conditional-subtract step: o_r = (2*i_r + i_b) mod i_m, given i_r < i_m.
module divn_step #(
  parameter int MW = 5
) (
  input  logic [MW-1:0] i_r,
  input  logic          i_b,
  input  logic [MW-1:0] i_m,
  output logic [MW-1:0] o_r
);

  logic [MW:0] w_t;
  logic [MW:0] w_m;

  assign w_t = {i_r, i_b};
  assign w_m = {1'b0, i_m};

  // The result of the subtract always fits in MW bits because i_r < i_m.
  always_comb begin
    o_r = MW'(w_t);
    if (w_t >= w_m) begin
      o_r = MW'(w_t - w_m);
    end
  end

endmodule

// File: rtl/divisible_n_stream.sv
// Streaming residue tracker: BITS bits per valid beat, MSB-first, modulo a
// modulus latched on start beats; results registered one cycle after each beat.
module divisible_n_stream
  import divn_pkg::*;
#(
  parameter int MAX_MOD = 16,
  parameter int BITS    = 2,
  parameter int DEF_MOD = 5,
  localparam int MW     = calc_mw(MAX_MOD)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_start,
  input  logic [BITS-1:0] in_bits,
  input  logic [MW-1:0]   mod_in,
  output logic            out_valid,
  output logic            out_div,
  output logic [MW-1:0]   out_rem,
  output logic            out_err
);

  localparam logic [MW-1:0] MAX_MOD_W = MW'(MAX_MOD);
  localparam logic [MW-1:0] DEF_MOD_W = MW'(DEF_MOD);

  logic [MW-1:0]      r_rem;
  logic [MW-1:0]      r_mod;
  logic [ERR_NUM-1:0] r_err;
  logic               r_valid;
  logic               r_div;

  logic               w_start;
  logic               w_illegal;
  logic [MW-1:0]      w_mod;
  logic [MW-1:0]      w_base;
  logic [ERR_NUM-1:0] w_err_next;
  logic [MW-1:0]      w_rem_calc;
  logic [MW-1:0]      w_rem_next;

  assign w_start   = in_valid & in_start;
  assign w_illegal = (mod_in == '0) || (mod_in > MAX_MOD_W);
  assign w_mod     = w_start ? mod_in : r_mod;
  assign w_base    = w_start ? '0 : r_rem;

  always_comb begin
    w_err_next = r_err;
    if (w_start) begin
      w_err_next                  = '0;
      w_err_next[ERR_ILLEGAL_MOD] = w_illegal;
    end
  end

  // Chain of single-bit reduction steps, most significant input bit first.
  for (genvar gi = 0; gi < BITS; gi++) begin : g_step
    logic [MW-1:0] w_r_in;
    logic [MW-1:0] w_r_out;
    if (gi == 0) begin : g_first
      assign w_r_in = w_base;
    end else begin : g_next
      assign w_r_in = g_step[gi-1].w_r_out;
    end
    divn_step #(.MW(MW)) u_step (
      .i_r (w_r_in),
      .i_b (in_bits[BITS-1-gi]),
      .i_m (w_mod),
      .o_r (w_r_out)
    );
  end

  assign w_rem_calc = g_step[BITS-1].w_r_out;
  // Any error pins the residue at zero so the frame stays well defined.
  assign w_rem_next = (|w_err_next) ? '0 : w_rem_calc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem   <= '0;
      r_mod   <= DEF_MOD_W;
      r_err   <= '0;
      r_valid <= 1'b0;
      r_div   <= 1'b1;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_mod <= w_mod;
        r_err <= w_err_next;
        r_rem <= w_rem_next;
        r_div <= (w_rem_next == '0) && !(|w_err_next);
      end
    end
  end

  assign out_valid = r_valid;
  assign out_div   = r_div;
  assign out_rem   = r_rem;
  assign out_err   = r_err[ERR_ILLEGAL_MOD];

endmodule

// File: tb/tb_divisible_n_stream.sv
// Directed bench for divisible_n_stream with MAX_MOD=16, BITS=2, DEF_MOD=5.
module tb_divisible_n_stream;

  localparam int MAX_MOD = 16;
  localparam int BITS    = 2;
  localparam int DEF_MOD = 5;
  localparam int MW      = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_start;
  logic [BITS-1:0] in_bits;
  logic [MW-1:0]   mod_in;
  logic            out_valid;
  logic            out_div;
  logic [MW-1:0]   out_rem;
  logic            out_err;

  int total = 0;
  int bad   = 0;

  divisible_n_stream #(
    .MAX_MOD (MAX_MOD),
    .BITS    (BITS),
    .DEF_MOD (DEF_MOD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_start  (in_start),
    .in_bits   (in_bits),
    .mod_in    (mod_in),
    .out_valid (out_valid),
    .out_div   (out_div),
    .out_rem   (out_rem),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then sample 1 time unit after the capturing edge.
  task automatic step(input logic r, input logic v, input logic s,
                      input logic [BITS-1:0] b, input logic [MW-1:0] m);
    rst      = r;
    in_valid = v;
    in_start = s;
    in_bits  = b;
    mod_in   = m;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic e_valid, input logic [MW-1:0] e_rem,
                     input logic e_div, input logic e_err);
    total++;
    assert (out_valid === e_valid) else begin
      bad++;
      $error("FAIL %s out_valid observed=%0b expected=%0b", tag, out_valid, e_valid);
    end
    total++;
    assert (out_rem === e_rem) else begin
      bad++;
      $error("FAIL %s out_rem observed=%0d expected=%0d", tag, out_rem, e_rem);
    end
    total++;
    assert (out_div === e_div) else begin
      bad++;
      $error("FAIL %s out_div observed=%0b expected=%0b", tag, out_div, e_div);
    end
    total++;
    assert (out_err === e_err) else begin
      bad++;
      $error("FAIL %s out_err observed=%0b expected=%0b", tag, out_err, e_err);
    end
  endtask

  initial begin
    step(1, 0, 0, 2'b00, 5'd0);
    step(1, 0, 0, 2'b00, 5'd0);
    chk("reset", 0, 0, 1, 0);

    // Default modulus 5, value 0b1010 = 10.
    step(0, 1, 0, 2'b10, 5'd0);   chk("def_b0", 1, 2, 0, 0);
    step(0, 1, 0, 2'b10, 5'd0);   chk("def_b1", 1, 0, 1, 0);
    step(0, 0, 0, 2'b00, 5'd0);   chk("def_idle", 0, 0, 1, 0);

    // Modulus 3, value 0b1101 = 13.
    step(0, 1, 1, 2'b11, 5'd3);   chk("m3_b0", 1, 0, 1, 0);
    step(0, 1, 0, 2'b01, 5'd9);   chk("m3_b1", 1, 1, 0, 0);

    // Modulus 16 (largest legal), value 255.
    step(0, 1, 1, 2'b11, 5'd16);  chk("m16_b0", 1, 3, 0, 0);
    step(0, 1, 0, 2'b11, 5'd0);   chk("m16_b1", 1, 15, 0, 0);
    step(0, 1, 0, 2'b11, 5'd0);   chk("m16_b2", 1, 15, 0, 0);
    step(0, 1, 0, 2'b11, 5'd0);   chk("m16_b3", 1, 15, 0, 0);

    // Illegal modulus 0 is sticky, then a legal start clears it.
    step(0, 1, 1, 2'b11, 5'd0);   chk("m0_b0", 1, 0, 0, 1);
    step(0, 1, 0, 2'b10, 5'd0);   chk("m0_b1", 1, 0, 0, 1);
    step(0, 0, 0, 2'b00, 5'd0);   chk("m0_idle", 0, 0, 0, 1);
    step(0, 1, 0, 2'b01, 5'd3);   chk("m0_b2", 1, 0, 0, 1);
    step(0, 1, 1, 2'b00, 5'd7);   chk("m7_clear", 1, 0, 1, 0);

    // Modulus 17 exceeds MAX_MOD.
    step(0, 1, 1, 2'b01, 5'd17);  chk("m17_err", 1, 0, 0, 1);

    // Modulus 1: residue always 0.
    step(0, 1, 1, 2'b11, 5'd1);   chk("m1_b0", 1, 0, 1, 0);
    step(0, 1, 0, 2'b01, 5'd0);   chk("m1_b1", 1, 0, 1, 0);

    // Back-to-back starts: mod 3 bits 10 -> 2, then mod 4 bits 11 -> 3.
    step(0, 1, 1, 2'b10, 5'd3);   chk("b2b_0", 1, 2, 0, 0);
    step(0, 1, 1, 2'b11, 5'd4);   chk("b2b_1", 1, 3, 0, 0);

    // Gaps mid-frame, with a stray start while idle; value 0b110110 = 54 mod 5 = 4.
    step(0, 1, 1, 2'b11, 5'd5);   chk("gap_b0", 1, 3, 0, 0);
    step(0, 1, 0, 2'b01, 5'd0);   chk("gap_b1", 1, 3, 0, 0);
    step(0, 0, 0, 2'b10, 5'd0);   chk("gap_i0", 0, 3, 0, 0);
    step(0, 0, 1, 2'b00, 5'd7);   chk("gap_i1", 0, 3, 0, 0);
    step(0, 0, 0, 2'b11, 5'd0);   chk("gap_i2", 0, 3, 0, 0);
    step(0, 1, 0, 2'b10, 5'd0);   chk("gap_b2", 1, 4, 0, 0);

    // Reset wins over a valid beat; then DEF_MOD=5 is back in effect.
    step(1, 1, 0, 2'b11, 5'd0);   chk("rst_mid", 0, 0, 1, 0);
    step(0, 1, 0, 2'b01, 5'd0);   chk("post_rst_b0", 1, 1, 0, 0);

    // Switch to mod 7, reset, then 0b1111 = 15: mod 5 -> 0 (mod 7 would give 1).
    step(0, 1, 1, 2'b10, 5'd7);   chk("m7_pre", 1, 2, 0, 0);
    step(1, 0, 0, 2'b00, 5'd0);   chk("rst2", 0, 0, 1, 0);
    step(0, 1, 0, 2'b11, 5'd0);   chk("post_rst2_b0", 1, 3, 0, 0);
    step(0, 1, 0, 2'b11, 5'd0);   chk("post_rst2_b1", 1, 0, 1, 0);

    step(0, 0, 0, 2'b00, 5'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
